// File: rtl/osiris_pkg.sv
// Shared encodings for the execute stage: M-extension funct3, MD unit states,
// forwarding selects and ALU operation codes.
package osiris_pkg;

    typedef enum logic [2:0] {
        MD_MUL    = 3'b000,
        MD_MULH   = 3'b001,
        MD_MULHSU = 3'b010,
        MD_MULHU  = 3'b011,
        MD_DIV    = 3'b100,
        MD_DIVU   = 3'b101,
        MD_REM    = 3'b110,
        MD_REMU   = 3'b111
    } md_op_e;

    typedef enum logic [1:0] {
        MD_IDLE = 2'b00,
        MD_BUSY = 2'b01,
        MD_DONE = 2'b10
    } md_state_e;

    localparam logic [1:0] FWD_REG = 2'b00;
    localparam logic [1:0] FWD_WB  = 2'b01;
    localparam logic [1:0] FWD_M   = 2'b10;

    localparam logic [4:0] ALU_ADD   = 5'd0;
    localparam logic [4:0] ALU_SUB   = 5'd1;
    localparam logic [4:0] ALU_AND   = 5'd2;
    localparam logic [4:0] ALU_OR    = 5'd3;
    localparam logic [4:0] ALU_XOR   = 5'd4;
    localparam logic [4:0] ALU_SLL   = 5'd5;
    localparam logic [4:0] ALU_SRL   = 5'd6;
    localparam logic [4:0] ALU_SRA   = 5'd7;
    localparam logic [4:0] ALU_SLT   = 5'd8;
    localparam logic [4:0] ALU_SLTU  = 5'd9;
    localparam logic [4:0] ALU_PASSB = 5'd10;

    function automatic logic md_rs1_signed(input logic [2:0] op);
        return (op == MD_MULH) || (op == MD_MULHSU) || (op == MD_DIV) || (op == MD_REM);
    endfunction

    function automatic logic md_rs2_signed(input logic [2:0] op);
        return (op == MD_MULH) || (op == MD_DIV) || (op == MD_REM);
    endfunction

endpackage

// File: rtl/stage_execute_md_mdu_iter.sv
// Iterative radix-2 multiply / restoring divide on operand magnitudes, one bit
// per cycle, with the sign fix-up applied when the result is presented.
module mdu_iter
    import osiris_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [2:0]            op,
    input  logic [DATA_WIDTH-1:0] rs1,
    input  logic [DATA_WIDTH-1:0] rs2,
    input  logic                  flush,
    output logic                  busy,
    output logic                  done,
    output logic [DATA_WIDTH-1:0] result
);

    localparam int W  = DATA_WIDTH;
    localparam int CW = $clog2(DATA_WIDTH);

    md_state_e      state;
    logic [CW-1:0]  count;
    logic [2:0]     op_q;
    logic [W-1:0]   hi, lo, dvs;
    logic           neg_lo, neg_hi;

    logic           is_div, a_neg, b_neg, div_zero, div_ovf;
    logic [W-1:0]   a_mag, b_mag;

    always_comb begin
        is_div   = op[2];
        a_neg    = md_rs1_signed(op) & rs1[W-1];
        b_neg    = md_rs2_signed(op) & rs2[W-1];
        a_mag    = a_neg ? -rs1 : rs1;
        b_mag    = b_neg ? -rs2 : rs2;
        div_zero = is_div & (rs2 == '0);
        div_ovf  = is_div & ~op[0] & (rs1 == {1'b1, {(W-1){1'b0}}}) & (rs2 == '1);
    end

    // hi:lo is the product shift register for multiply, remainder:quotient for divide
    logic [W:0] mul_sum, rem_shift, rem_diff;
    logic       rem_ge;

    always_comb begin
        mul_sum   = {1'b0, hi} + (lo[0] ? {1'b0, dvs} : '0);
        rem_shift = {hi, lo[W-1]};
        rem_diff  = rem_shift - {1'b0, dvs};
        rem_ge    = (rem_shift >= {1'b0, dvs});
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= MD_IDLE;
            count  <= '0;
            op_q   <= '0;
            hi     <= '0;
            lo     <= '0;
            dvs    <= '0;
            neg_lo <= 1'b0;
            neg_hi <= 1'b0;
        end else if (flush) begin
            state <= MD_IDLE;
        end else begin
            case (state)
                MD_IDLE: begin
                    if (start) begin
                        op_q  <= op;
                        count <= '0;
                        if (div_zero) begin
                            hi     <= rs1;
                            lo     <= '1;
                            dvs    <= '0;
                            neg_lo <= 1'b0;
                            neg_hi <= 1'b0;
                            state  <= MD_DONE;
                        end else if (div_ovf) begin
                            hi     <= '0;
                            lo     <= rs1;
                            dvs    <= '0;
                            neg_lo <= 1'b0;
                            neg_hi <= 1'b0;
                            state  <= MD_DONE;
                        end else if (is_div) begin
                            hi     <= '0;
                            lo     <= a_mag;
                            dvs    <= b_mag;
                            neg_lo <= a_neg ^ b_neg;
                            neg_hi <= a_neg;
                            state  <= MD_BUSY;
                        end else begin
                            hi     <= '0;
                            lo     <= b_mag;
                            dvs    <= a_mag;
                            neg_lo <= a_neg ^ b_neg;
                            neg_hi <= 1'b0;
                            state  <= MD_BUSY;
                        end
                    end
                end
                MD_BUSY: begin
                    if (op_q[2]) begin
                        hi <= rem_ge ? rem_diff[W-1:0] : rem_shift[W-1:0];
                        lo <= {lo[W-2:0], rem_ge};
                    end else begin
                        hi <= mul_sum[W:1];
                        lo <= {mul_sum[0], lo[W-1:1]};
                    end
                    if (count == CW'(W - 1)) begin
                        state <= MD_DONE;
                    end else begin
                        count <= count + 1'b1;
                    end
                end
                MD_DONE: state <= MD_IDLE;
                default: state <= MD_IDLE;
            endcase
        end
    end

    logic [2*W-1:0] prod;

    always_comb begin
        prod = {hi, lo};
        if (neg_lo) prod = -prod;
        case (op_q)
            MD_MUL:                       result = prod[W-1:0];
            MD_MULH, MD_MULHSU, MD_MULHU: result = prod[2*W-1:W];
            MD_DIV, MD_DIVU:              result = neg_lo ? -lo : lo;
            default:                      result = neg_hi ? -hi : hi;
        endcase
    end

    assign busy = (state == MD_BUSY) & ~flush;
    assign done = (state == MD_DONE) & ~flush;

endmodule

// File: rtl/stage_execute_md.sv
// Execute stage: operand forwarding, ALU and branch target, plus an optional
// iterative M-extension unit that stalls the front of the pipe while it runs.
module stage_execute_md
    import osiris_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter bit MD_EN      = 1'b1
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic [DATA_WIDTH-1:0] i_rd1_EX,
    input  logic [DATA_WIDTH-1:0] i_rd2_EX,
    input  logic [DATA_WIDTH-1:0] i_pc_EX,
    input  logic [DATA_WIDTH-1:0] i_imm_ext_EX,
    input  logic [DATA_WIDTH-1:0] i_result_WB,
    input  logic [DATA_WIDTH-1:0] i_alu_result_M,
    input  logic [1:0]            i_forward_rs1_EX,
    input  logic [1:0]            i_forward_rs2_EX,
    input  logic                  i_alu_src_EX,
    input  logic [4:0]            i_alu_ctrl_EX,
    input  logic                  i_valid_EX,
    input  logic                  i_md_en_EX,
    input  logic [2:0]            i_md_op_EX,
    input  logic                  i_flush_EX,
    output logic [DATA_WIDTH-1:0] o_alu_result_EX,
    output logic [DATA_WIDTH-1:0] o_write_data_EX,
    output logic [DATA_WIDTH-1:0] o_pc_target_EX,
    output logic                  o_equal_EX,
    output logic                  o_stall_EX,
    output logic                  o_md_done_EX
);

    localparam int W  = DATA_WIDTH;
    localparam int SW = $clog2(DATA_WIDTH);

    logic [W-1:0]        src_a, src_b_fwd, src_b, alu_result, md_result;
    logic signed [W-1:0] src_a_s, src_b_s;
    logic                md_req, md_start, md_busy, md_done;

    always_comb begin
        case (i_forward_rs1_EX)
            FWD_WB:  src_a = i_result_WB;
            FWD_M:   src_a = i_alu_result_M;
            default: src_a = i_rd1_EX;
        endcase
        case (i_forward_rs2_EX)
            FWD_WB:  src_b_fwd = i_result_WB;
            FWD_M:   src_b_fwd = i_alu_result_M;
            default: src_b_fwd = i_rd2_EX;
        endcase
    end

    assign src_b   = i_alu_src_EX ? i_imm_ext_EX : src_b_fwd;
    assign src_a_s = src_a;
    assign src_b_s = src_b;

    always_comb begin
        case (i_alu_ctrl_EX)
            ALU_ADD:   alu_result = src_a + src_b;
            ALU_SUB:   alu_result = src_a - src_b;
            ALU_AND:   alu_result = src_a & src_b;
            ALU_OR:    alu_result = src_a | src_b;
            ALU_XOR:   alu_result = src_a ^ src_b;
            ALU_SLL:   alu_result = src_a << src_b[SW-1:0];
            ALU_SRL:   alu_result = src_a >> src_b[SW-1:0];
            ALU_SRA:   alu_result = src_a_s >>> src_b[SW-1:0];
            ALU_SLT:   alu_result = {{(W-1){1'b0}}, src_a_s < src_b_s};
            ALU_SLTU:  alu_result = {{(W-1){1'b0}}, src_a < src_b};
            ALU_PASSB: alu_result = src_b;
            default:   alu_result = '0;
        endcase
    end

    assign o_pc_target_EX  = i_pc_EX + i_imm_ext_EX;
    assign o_write_data_EX = src_b_fwd;

    // The unit is idle exactly when it is neither busy nor presenting a result
    assign md_req   = MD_EN & i_rst_n & i_valid_EX & i_md_en_EX & ~i_flush_EX;
    assign md_start = md_req & ~md_busy & ~md_done;

    generate
        if (MD_EN) begin : g_md
            mdu_iter #(
                .DATA_WIDTH (DATA_WIDTH)
            ) u_mdu (
                .clk    (i_clk),
                .rst_n  (i_rst_n),
                .start  (md_start),
                .op     (i_md_op_EX),
                .rs1    (src_a),
                .rs2    (src_b_fwd),
                .flush  (i_flush_EX),
                .busy   (md_busy),
                .done   (md_done),
                .result (md_result)
            );
        end else begin : g_no_md
            assign md_busy   = 1'b0;
            assign md_done   = 1'b0;
            assign md_result = '0;
        end
    endgenerate

    assign o_alu_result_EX = md_done ? md_result : alu_result;
    assign o_equal_EX      = (src_a == src_b) & ~md_done;
    assign o_stall_EX      = md_start | md_busy;
    assign o_md_done_EX    = md_done;

endmodule

// File: tb/tb_stage_execute_md.sv
// Directed bench for stage_execute_md at DATA_WIDTH=32 with the MD unit enabled.
module tb_stage_execute_md;
    import osiris_pkg::*;

    logic        clk;
    logic        rst_n;
    logic [31:0] rd1, rd2, pc, imm, wb, m_val;
    logic [1:0]  fwd1, fwd2;
    logic        alu_src;
    logic [4:0]  alu_ctrl;
    logic        valid, md_en, flush;
    logic [2:0]  md_op;
    logic [31:0] alu_result, write_data, pc_target;
    logic        equal, stall, md_done;

    int errors = 0;
    int checks = 0;
    bit seen;

    stage_execute_md #(
        .DATA_WIDTH (32),
        .MD_EN      (1'b1)
    ) dut (
        .i_clk            (clk),
        .i_rst_n          (rst_n),
        .i_rd1_EX         (rd1),
        .i_rd2_EX         (rd2),
        .i_pc_EX          (pc),
        .i_imm_ext_EX     (imm),
        .i_result_WB      (wb),
        .i_alu_result_M   (m_val),
        .i_forward_rs1_EX (fwd1),
        .i_forward_rs2_EX (fwd2),
        .i_alu_src_EX     (alu_src),
        .i_alu_ctrl_EX    (alu_ctrl),
        .i_valid_EX       (valid),
        .i_md_en_EX       (md_en),
        .i_md_op_EX       (md_op),
        .i_flush_EX       (flush),
        .o_alu_result_EX  (alu_result),
        .o_write_data_EX  (write_data),
        .o_pc_target_EX   (pc_target),
        .o_equal_EX       (equal),
        .o_stall_EX       (stall),
        .o_md_done_EX     (md_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Issue one MD op, count stall cycles, then check the DONE cycle and return to idle
    task automatic run_md(input string tag, input logic [2:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [1:0] f1, input logic [31:0] mv,
                          input bit perturb, input logic [31:0] exp, input int exp_n);
        int n;
        md_op = op; rd1 = a; rd2 = b; fwd1 = f1; fwd2 = FWD_REG; m_val = mv;
        alu_src = 1'b0; valid = 1'b1; md_en = 1'b1;
        #1;
        n = 0;
        while (stall && n < 100) begin
            n++;
            @(posedge clk); #1;
            if (perturb) begin
                m_val = 32'd9; rd1 = 32'd50; rd2 = 32'd77;
            end
        end
        check({tag, "_stall_cycles"}, 32'(n), 32'(exp_n));
        check({tag, "_done"}, {31'b0, md_done}, 32'd1);
        check({tag, "_result"}, alu_result, exp);
        check({tag, "_equal"}, {31'b0, equal}, 32'd0);
        valid = 1'b0; md_en = 1'b0; fwd1 = FWD_REG;
        @(posedge clk); #1;
        check({tag, "_idle"}, {30'b0, stall, md_done}, 32'd0);
    endtask

    initial begin
        rst_n = 1'b0; rd1 = 32'd5; rd2 = 32'h33; pc = 32'h100; imm = 32'd7;
        wb = 32'h40; m_val = 32'h200; fwd1 = FWD_REG; fwd2 = FWD_REG;
        alu_src = 1'b1; alu_ctrl = ALU_ADD; valid = 1'b1; md_en = 1'b0;
        md_op = MD_MUL; flush = 1'b0;
        #3;
        check("rst_stall", {31'b0, stall}, 32'd0);
        check("rst_done", {31'b0, md_done}, 32'd0);
        check("rst_alu_comb", alu_result, 32'd12);
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_n = 1'b1;
        #1;
        // Plain ALU path
        check("add_result", alu_result, 32'd12);
        check("add_stall", {31'b0, stall}, 32'd0);
        check("pc_target", pc_target, 32'h107);
        check("write_data", write_data, 32'h33);
        rd1 = 32'h33; alu_src = 1'b0; alu_ctrl = ALU_SUB; #1;
        check("sub_result", alu_result, 32'd0);
        check("sub_equal", {31'b0, equal}, 32'd1);
        fwd1 = FWD_WB; rd2 = 32'h10; alu_ctrl = ALU_ADD; #1;
        check("fwd_wb_add", alu_result, 32'h50);
        check("fwd_wb_equal", {31'b0, equal}, 32'd0);
        fwd2 = FWD_M; #1;
        check("fwd_m_store", write_data, 32'h200);
        check("fwd_m_add", alu_result, 32'h240);
        valid = 1'b0; fwd1 = FWD_REG; fwd2 = FWD_REG;
        @(posedge clk); #1;

        run_md("mul", MD_MUL, 32'hFFFFFFFF, 32'hFFFFFFFF, FWD_REG, 32'd0, 1'b0, 32'h00000001, 33);
        run_md("mulhu", MD_MULHU, 32'hFFFFFFFF, 32'hFFFFFFFF, FWD_REG, 32'd0, 1'b0, 32'hFFFFFFFE, 33);
        run_md("mulh", MD_MULH, 32'hFFFFFFFF, 32'hFFFFFFFF, FWD_REG, 32'd0, 1'b0, 32'h00000000, 33);
        run_md("mulhsu", MD_MULHSU, 32'hFFFFFFFE, 32'd3, FWD_REG, 32'd0, 1'b0, 32'hFFFFFFFF, 33);
        run_md("div", MD_DIV, 32'hFFFFFFF9, 32'd2, FWD_REG, 32'd0, 1'b0, 32'hFFFFFFFD, 33);
        run_md("rem", MD_REM, 32'hFFFFFFF9, 32'd2, FWD_REG, 32'd0, 1'b0, 32'hFFFFFFFF, 33);
        run_md("remu", MD_REMU, 32'd100, 32'd7, FWD_REG, 32'd0, 1'b0, 32'd2, 33);
        run_md("divu_zero", MD_DIVU, 32'd100, 32'd0, FWD_REG, 32'd0, 1'b0, 32'hFFFFFFFF, 1);
        run_md("rem_zero", MD_REM, 32'hFFFFFFF9, 32'd0, FWD_REG, 32'd0, 1'b0, 32'hFFFFFFF9, 1);
        run_md("rem_ovf", MD_REM, 32'h80000000, 32'hFFFFFFFF, FWD_REG, 32'd0, 1'b0, 32'h00000000, 1);
        run_md("div_ovf", MD_DIV, 32'h80000000, 32'hFFFFFFFF, FWD_REG, 32'd0, 1'b0, 32'h80000000, 1);
        run_md("mul_fwd", MD_MUL, 32'h55, 32'd4, FWD_M, 32'd3, 1'b1, 32'd12, 33);

        // Flush in the tenth BUSY cycle
        md_op = MD_MUL; rd1 = 32'd6; rd2 = 32'd7; valid = 1'b1; md_en = 1'b1;
        #1;
        check("flush_accept_stall", {31'b0, stall}, 32'd1);
        repeat (10) @(posedge clk);
        #1;
        check("flush_busy_stall", {31'b0, stall}, 32'd1);
        flush = 1'b1; #1;
        check("flush_stall_drop", {31'b0, stall}, 32'd0);
        check("flush_done_low", {31'b0, md_done}, 32'd0);
        @(posedge clk); #1;
        flush = 1'b0; valid = 1'b0; md_en = 1'b0;
        seen = 1'b0;
        repeat (40) begin
            @(posedge clk); #1;
            if (md_done || stall) seen = 1'b1;
        end
        check("flush_no_done", {31'b0, seen}, 32'd0);
        run_md("divu_after_flush", MD_DIVU, 32'd9, 32'd3, FWD_REG, 32'd0, 1'b0, 32'd3, 33);

        // Reset in the fifth BUSY cycle
        md_op = MD_DIV; rd1 = 32'd1000; rd2 = 32'd10; valid = 1'b1; md_en = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        check("rst_busy_stall", {31'b0, stall}, 32'd1);
        rst_n = 1'b0; #1;
        check("rst_stall_drop", {31'b0, stall}, 32'd0);
        check("rst_done_low", {31'b0, md_done}, 32'd0);
        @(posedge clk); #1;
        valid = 1'b0; md_en = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        seen = 1'b0;
        repeat (40) begin
            @(posedge clk); #1;
            if (md_done || stall) seen = 1'b1;
        end
        check("rst_no_done", {31'b0, seen}, 32'd0);
        run_md("divu_after_rst", MD_DIVU, 32'd9, 32'd3, FWD_REG, 32'd0, 1'b0, 32'd3, 33);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/stage_execute_md.md
STAGE_EXECUTE_MD -- requirements
Module: stage_execute_md

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, meaning datapath width W (W even, >=8).
REQ-002 SHALL have parameter MD_EN, default 1, meaning 1 instantiates the iterative multiply/divide unit; 0 ties all MD outputs inactive.
REQ-003 SHALL have port i_clk  input  1  single clock, rising edge.
REQ-004 SHALL have port i_rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have ports i_rd1_EX, i_rd2_EX, i_pc_EX, i_imm_ext_EX, i_result_WB, i_alu_result_M  input  W  register operands, PC, extended immediate, WB and M forwarding values.
REQ-006 SHALL have ports i_forward_rs1_EX, i_forward_rs2_EX  input  2  forwarding select: 00 register, 01 WB, 10 M, 11 register.
REQ-007 SHALL have port i_alu_src_EX  input  1  0 selects forwarded rs2, 1 selects immediate as ALU operand B.
REQ-008 SHALL have port i_alu_ctrl_EX  input  5  existing ALU operation code.
REQ-009 SHALL have ports i_valid_EX  input  1  EX holds a real instruction; i_md_en_EX  input  1  instruction is an M-extension op; i_md_op_EX  input  3  RISC-V M funct3 (MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU).
REQ-010 SHALL have port i_flush_EX  input  1  kill the EX instruction, including any MD op in flight.
REQ-011 SHALL have ports o_alu_result_EX, o_write_data_EX, o_pc_target_EX  output  W  result, forwarded rs2 (store data), i_pc_EX+i_imm_ext_EX modulo 2^W.
REQ-012 SHALL have ports o_equal_EX  output  1  ALU equality flag; o_stall_EX  output  1  hold IF/ID/EX; o_md_done_EX  output  1  MD result presented this cycle.

Function
REQ-013 Non-MD instructions SHALL be purely combinational: forwarding muxes, operand-B mux, ALU; o_stall_EX=0.
REQ-014 Unit SHALL have states IDLE, BUSY, DONE.
REQ-015 In IDLE with i_valid_EX & i_md_en_EX & !i_flush_EX, unit SHALL latch forwarded rs1/rs2 (never the immediate) and op, assert o_stall_EX combinationally, and enter BUSY (or DONE for special cases, REQ-019).
REQ-016 BUSY SHALL run exactly W iterations (radix-2 shift-add multiply, restoring divide on magnitudes), counter 0..W-1, then enter DONE.
REQ-017 o_stall_EX SHALL be high in the accept cycle and every BUSY cycle (W+1 cycles total), and low in DONE.
REQ-018 In DONE, o_alu_result_EX SHALL carry the MD result, o_md_done_EX=1, o_equal_EX=0; next state IDLE unconditionally; no acceptance occurs in DONE.
REQ-019 Divide by zero SHALL skip BUSY (accept -> DONE, stall 1 cycle): DIV/DIVU quotient all ones, REM/REMU remainder = dividend.
REQ-020 Signed overflow (DIV/REM with dividend -2^(W-1), divisor -1) SHALL skip BUSY: quotient = dividend, remainder = 0.
REQ-021 MUL SHALL return product bits [W-1:0]; MULH/MULHSU/MULHU bits [2W-1:W] of the signed-signed, signed-unsigned, unsigned-unsigned 2W-bit product.
REQ-022 Signed divide SHALL truncate toward zero; quotient sign = XOR of operand signs, remainder sign = dividend sign.
REQ-023 i_flush_EX SHALL force o_stall_EX=0 and o_md_done_EX=0 combinationally and next state IDLE from any state, discarding results.
REQ-024 Forwarding/mux inputs changing during BUSY SHALL not affect the MD result.
REQ-025 MD_EN=0: o_stall_EX=0, o_md_done_EX=0, MD ops produce ALU result for i_alu_ctrl_EX.

Reset
REQ-026 i_rst_n low SHALL asynchronously force state IDLE, counter 0, operand/accumulator registers 0, o_stall_EX=0, o_md_done_EX=0; combinational outputs follow inputs.
REQ-027 Reset mid-operation SHALL abandon the op; after release the unit accepts a new op only in IDLE.

Structure
REQ-028 MD funct3 encodings, state encodings and the forwarding-select codes SHALL live in shared package osiris_pkg.
REQ-029 Iterative unit SHALL be sub-module mdu_iter (clock, reset, start, op, operands, flush, busy, done, result); existing alu, pc_target and mux instances are reused unchanged.

Verification
REQ-030 ADD rd1=5, imm=7, alu_src=1 -> result 12 same cycle, stall 0.
REQ-031 MUL 0xFFFFFFFF x 0xFFFFFFFF, W=32 -> stall 33 cycles, DONE result 0x00000001; MULHU -> 0xFFFFFFFE; MULH -> 0x00000000.
REQ-032 DIV -7 / 2 -> quotient 0xFFFFFFFD (-3); REM -> 0xFFFFFFFF (-1); 33 stall cycles each.
REQ-033 DIVU 100 / 0 -> stall 1 cycle, 0xFFFFFFFF; REM 0x80000000 / -1 -> stall 1 cycle, 0x00000000.
REQ-034 MUL 3 x 4 with forward_rs1=10 (M=3); change i_alu_result_M to 9 during BUSY -> result 12.
REQ-035 Flush at BUSY cycle 10, and i_rst_n low at BUSY cycle 5 -> stall drops immediately, no o_md_done_EX pulse, next DIVU 9/3 -> 3.
